// File: rtl/vga_timing_pkg.sv
// Shared VGA mode descriptions and helpers for the raster timing generator.
package vga_timing_pkg;

  // Timing of one raster axis, in pixels (horizontal) or lines (vertical)
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        active_high;
  } vga_axis_t;

  // Complete video mode: both axes plus the nominal pixel rate
  typedef struct packed {
    vga_axis_t   h;
    vga_axis_t   v;
    int unsigned pixel_khz;
  } vga_mode_t;

  localparam vga_mode_t MODE_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96, bp: 48, active_high: 1'b0},
    v: '{active: 480, fp: 10, sync: 2, bp: 33, active_high: 1'b0},
    pixel_khz: 25000
  };

  localparam vga_mode_t MODE_800x600_60 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88, active_high: 1'b1},
    v: '{active: 600, fp: 1, sync: 4, bp: 23, active_high: 1'b1},
    pixel_khz: 40000
  };

  // Period of one axis (line length or frame height)
  function automatic int unsigned total(input vga_axis_t axis);
    return axis.active + axis.fp + axis.sync + axis.bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag and registered sync decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter vga_axis_t   AXIS = MODE_640x480_60.h,
  parameter int unsigned CW   = 14
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          restart,
  input  logic          advance,
  output logic [CW-1:0] pos,
  output logic          wrap_c,
  output logic          sync,
  output logic          active_nxt_c
);

  localparam int unsigned TOTAL      = total(AXIS);
  localparam int unsigned SYNC_START = AXIS.active + AXIS.fp;
  localparam int unsigned SYNC_END   = SYNC_START + AXIS.sync;
  localparam logic        SYNC_ON    = AXIS.active_high;

  logic [CW-1:0] pos_nxt;
  logic          sync_nxt;

  // Next position and decodes of it, so registered outputs track pos
  always_comb begin
    wrap_c  = advance && (pos == CW'(TOTAL - 1));
    pos_nxt = pos;
    if (advance) begin
      pos_nxt = wrap_c ? '0 : pos + CW'(1);
    end
    sync_nxt     = ((pos_nxt >= CW'(SYNC_START)) && (pos_nxt < CW'(SYNC_END))) ? SYNC_ON : ~SYNC_ON;
    active_nxt_c = (pos_nxt < CW'(AXIS.active));
  end

  // Position and sync registers; restart behaves like reset
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pos  <= '0;
      sync <= ~SYNC_ON;
    end else if (restart) begin
      pos  <= '0;
      sync <= ~SYNC_ON;
    end else begin
      pos  <= pos_nxt;
      sync <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on a single clock with an internal pixel enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE       = MODE_640x480_60.h.active,
  parameter int unsigned H_FP           = MODE_640x480_60.h.fp,
  parameter int unsigned H_SYNC         = MODE_640x480_60.h.sync,
  parameter int unsigned H_BP           = MODE_640x480_60.h.bp,
  parameter int unsigned V_ACTIVE       = MODE_640x480_60.v.active,
  parameter int unsigned V_FP           = MODE_640x480_60.v.fp,
  parameter int unsigned V_SYNC         = MODE_640x480_60.v.sync,
  parameter int unsigned V_BP           = MODE_640x480_60.v.bp,
  parameter bit          HS_ACTIVE_HIGH = MODE_640x480_60.h.active_high,
  parameter bit          VS_ACTIVE_HIGH = MODE_640x480_60.v.active_high,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned CW             = 14
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          restart,
  output logic          px_ce,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam vga_axis_t H_AXIS = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP,
                                   active_high: HS_ACTIVE_HIGH};
  localparam vga_axis_t V_AXIS = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP,
                                   active_high: VS_ACTIVE_HIGH};
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          div_last_c;
  logic          h_wrap_c;
  logic          v_wrap_c;
  logic          h_active_c;
  logic          v_active_c;

  assign div_last_c = (div_cnt == DW'(CLK_DIV - 1));

  // Pixel-rate divider; px_ce follows the terminal count by one cycle
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      px_ce   <= 1'b0;
    end else if (restart) begin
      div_cnt <= '0;
      px_ce   <= 1'b0;
    end else begin
      div_cnt <= div_last_c ? '0 : div_cnt + DW'(1);
      px_ce   <= div_last_c;
    end
  end

  vga_axis_counter #(
    .AXIS (H_AXIS),
    .CW   (CW)
  ) u_h_axis (
    .clk_in       (clk_in),
    .rst          (rst),
    .restart      (restart),
    .advance      (px_ce),
    .pos          (hpos),
    .wrap_c       (h_wrap_c),
    .sync         (hsync),
    .active_nxt_c (h_active_c)
  );

  vga_axis_counter #(
    .AXIS (V_AXIS),
    .CW   (CW)
  ) u_v_axis (
    .clk_in       (clk_in),
    .rst          (rst),
    .restart      (restart),
    .advance      (h_wrap_c),
    .pos          (vpos),
    .wrap_c       (v_wrap_c),
    .sync         (vsync),
    .active_nxt_c (v_active_c)
  );

  // Data enable and wrap strobes, registered alongside the new position
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (restart) begin
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= h_active_c && v_active_c;
      line_start  <= h_wrap_c;
      frame_start <= v_wrap_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int unsigned CW = 14;

  typedef struct packed {
    logic          px_ce;
    logic [CW-1:0] hpos;
    logic [CW-1:0] vpos;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          ls;
    logic          fs;
  } obs_t;

  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic ra = 1'b0;
  logic rb = 1'b0;
  logic rc = 1'b0;

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  logic px_ce_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a;
  logic px_ce_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
  logic px_ce_c, hsync_c, vsync_c, de_c, line_start_c, frame_start_c;
  logic [CW-1:0] hpos_a, vpos_a, hpos_b, vpos_b, hpos_c, vpos_c;

  // Default 640x480 mode, divide by 4
  vga_timing_gen dut_a (
    .clk_in(clk_in), .rst(rst), .restart(ra), .px_ce(px_ce_a), .hpos(hpos_a), .vpos(vpos_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .line_start(line_start_a), .frame_start(frame_start_a)
  );

  // Tiny mode, no division, active-high syncs
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_ACTIVE_HIGH(1'b1), .VS_ACTIVE_HIGH(1'b1), .CLK_DIV(1), .CW(CW)
  ) dut_b (
    .clk_in(clk_in), .rst(rst), .restart(rb), .px_ce(px_ce_b), .hpos(hpos_b), .vpos(vpos_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .line_start(line_start_b), .frame_start(frame_start_b)
  );

  // Small mode with divide by 4, active-low syncs, short enough for whole frames
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_ACTIVE_HIGH(1'b0), .VS_ACTIVE_HIGH(1'b0), .CLK_DIV(4), .CW(CW)
  ) dut_c (
    .clk_in(clk_in), .rst(rst), .restart(rc), .px_ce(px_ce_c), .hpos(hpos_c), .vpos(vpos_c),
    .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .line_start(line_start_c), .frame_start(frame_start_c)
  );

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {px_ce_a, hpos_a, vpos_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a};
  assign obs_b = {px_ce_b, hpos_b, vpos_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b};
  assign obs_c = {px_ce_c, hpos_c, vpos_c, hsync_c, vsync_c, de_c, line_start_c, frame_start_c};

  // Expected outputs k clock edges after the last reset/restart edge.
  // n pixels have elapsed; position is n modulo the frame, split into column/line.
  function automatic obs_t model(input int k, input int d,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input bit hpol, input bit vpol);
    obs_t m;
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int n, p, h, v;
    n = (k == 0) ? 0 : (k - 1) / d;
    p = n % (ht * vt);
    h = p % ht;
    v = p / ht;
    m.px_ce = (k > 0) && (k % d == 0);
    m.hpos  = CW'(h);
    m.vpos  = CW'(v);
    m.hsync = (h >= ha + hf && h < ha + hf + hs) ? hpol : !hpol;
    m.vsync = (v >= va + vf && v < va + vf + vs) ? vpol : !vpol;
    m.de    = (h < ha) && (v < va);
    m.ls    = (k > d) && ((k - 1) % d == 0) && (h == 0);
    m.fs    = m.ls && (v == 0);
    return m;
  endfunction

  task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t got ce=%b h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b exp ce=%b h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
               nm, $time, act.px_ce, act.hpos, act.vpos, act.hsync, act.vsync, act.de, act.ls, act.fs,
               exp.px_ce, exp.hpos, exp.vpos, exp.hsync, exp.vsync, exp.de, exp.ls, exp.fs);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %0d exp %0d", nm, $time, act, exp);
    end
  endtask

  // Stimulus side of the scoreboard: each edge queues the state the DUTs should show next
  obs_t qa[$], qb[$], qc[$];
  int ka = 0, kb = 0, kc = 0;

  initial begin
    forever begin
      @(posedge clk_in);
      ka = (rst || ra) ? 0 : ka + 1;
      kb = (rst || rb) ? 0 : kb + 1;
      kc = (rst || rc) ? 0 : kc + 1;
      qa.push_back(model(ka, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
      qb.push_back(model(kb, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1));
      qc.push_back(model(kc, 4, 16, 2, 3, 3, 6, 1, 2, 1, 1'b0, 1'b0));
    end
  end

  // Monitor side: pop and compare away from the active edge
  initial begin
    forever begin
      @(negedge clk_in);
      if (qa.size() > 0) chk_obs("sb_a", obs_a, qa.pop_front());
      if (qb.size() > 0) chk_obs("sb_b", obs_b, qb.pop_front());
      if (qc.size() > 0) chk_obs("sb_c", obs_c, qc.pop_front());
    end
  end

  // Point checks of sync/de edges taken straight from the mode numbers
  bit seen10 = 1'b0;
  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst) begin
        if (hpos_a == 655) chk_int("a_hs_655", int'(hsync_a), 1);
        if (hpos_a == 656) chk_int("a_hs_656", int'(hsync_a), 0);
        if (hpos_a == 751) chk_int("a_hs_751", int'(hsync_a), 0);
        if (hpos_a == 752) chk_int("a_hs_752", int'(hsync_a), 1);
        if (hpos_a == 639) chk_int("a_de_639", int'(de_a), 1);
        if (hpos_a == 640) chk_int("a_de_640", int'(de_a), 0);
        if (line_start_a && vpos_a == 10) begin
          chk_int("a_v10_hpos", int'(hpos_a), 0);
          chk_int("a_v10_fs", int'(frame_start_a), 0);
          seen10 = 1'b1;
        end
        if (hpos_b == 4) chk_int("b_hs_4", int'(hsync_b), 0);
        if (hpos_b == 5) chk_int("b_hs_5", int'(hsync_b), 1);
        if (hpos_b == 6) chk_int("b_hs_6", int'(hsync_b), 1);
        if (hpos_b == 7) chk_int("b_hs_7", int'(hsync_b), 0);
        if (vpos_c == 6) chk_int("c_vs_6", int'(vsync_c), 1);
        if (vpos_c == 7) chk_int("c_vs_7", int'(vsync_c), 0);
        if (vpos_c == 8) chk_int("c_vs_8", int'(vsync_c), 0);
        if (vpos_c == 9) chk_int("c_vs_9", int'(vsync_c), 1);
      end
    end
  end

  function automatic bit pick(input int w);
    case (w)
      0:       return frame_start_c;
      1:       return line_start_b;
      2:       return frame_start_b;
      default: return px_ce_c;
    endcase
  endfunction

  // Cycles between two consecutive pulses of the selected signal; -1 on timeout
  task automatic gap(input int w, output int g);
    bit hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk_in);
      hit = pick(w);
    end
    g = -1;
    if (hit) begin
      hit = 1'b0;
      for (int i = 1; i <= 3000 && !hit; i++) begin
        @(negedge clk_in);
        if (pick(w)) begin
          hit = 1'b1;
          g = i;
        end
      end
    end
  endtask

  initial begin
    int cnt;
    int g;
    bit found;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk_in);
    chk_obs("reset_a", obs_a, {1'b0, CW'(0), CW'(0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;

    // First pixel enable CLK_DIV cycles after release, then every CLK_DIV
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      cnt++;
      found = px_ce_a;
    end
    chk_int("a_first_px_ce", cnt, 4);
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      cnt++;
      found = px_ce_a;
    end
    chk_int("a_px_ce_period", cnt, 4);

    // Random restart pulses (sometimes back to back) on the small configurations
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk_in);
      rb = ($urandom % 48 == 0);
      rc = ($urandom % 48 == 0);
      if (i == 3000) begin
        rb = 1'b1;
        repeat (10) @(negedge clk_in);
        chk_int("b_hold_h", int'(hpos_b), 0);
        chk_int("b_hold_v", int'(vpos_b), 0);
        rb = 1'b0;
      end
    end
    @(negedge clk_in);
    rb = 1'b0;
    rc = 1'b0;

    // Restart coincident with a pixel advance mid-frame
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk_in);
      found = px_ce_c && (hpos_c == 12) && (vpos_c == 5);
    end
    chk_int("c_restart_point", int'(found), 1);
    rc = 1'b1;
    @(negedge clk_in);
    rc = 1'b0;
    chk_int("c_rs_hpos", int'(hpos_c), 0);
    chk_int("c_rs_vpos", int'(vpos_c), 0);
    chk_int("c_rs_px_ce", int'(px_ce_c), 0);
    chk_int("c_rs_ls", int'(line_start_c), 0);
    chk_int("c_rs_fs", int'(frame_start_c), 0);
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      cnt++;
      found = px_ce_c;
    end
    chk_int("c_rs_first_px_ce", cnt, 4);
    gap(0, g);
    chk_int("c_frame_period", g, 960);

    gap(1, g);
    chk_int("b_line_period", g, 8);
    gap(2, g);
    chk_int("b_frame_period", g, 48);

    // Let the default mode reach line 10
    for (int i = 0; i < 40000 && !seen10; i++) @(negedge clk_in);
    chk_int("a_reached_v10", int'(seen10), 1);

    @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator; successor to the fixed 640x480 sync counter and its separate divide-by-4 clock.
- Runs entirely on clk_in. Pixel rate comes from an internal clock-enable divider, not a derived clock.
- Produces position counters, sync pulses of configurable polarity, data-enable, and line/frame strobes.
- Sits between the board clock and the pixel/framebuffer pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum of all four (800)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum of all four (525)
- HS_ACTIVE_HIGH, 0, hsync asserted level (0 = active-low)
- VS_ACTIVE_HIGH, 0, vsync asserted level (0 = active-low)
- CLK_DIV, 4, clk_in cycles per pixel; must be >= 1
- CW, 14, position counter width; H_TOTAL and V_TOTAL must be <= 2**CW

Ports:
- clk_in, in, 1, system clock; all state changes on posedge
- rst, in, 1, reset, asynchronous, active-high
- restart, in, 1, synchronous frame restart
- px_ce, out, 1, pixel clock enable: high 1 clk_in cycle out of every CLK_DIV
- hpos, out, CW, current pixel column, 0..H_TOTAL-1
- vpos, out, CW, current line, 0..V_TOTAL-1
- hsync, out, 1, horizontal sync at the configured polarity
- vsync, out, 1, vertical sync at the configured polarity
- de, out, 1, data enable: high while hpos < H_ACTIVE and vpos < V_ACTIVE
- line_start, out, 1, one-clk_in pulse when hpos wraps to 0
- frame_start, out, 1, one-clk_in pulse when (hpos,vpos) wraps to (0,0)

Behaviour:
- Reset, reset decided as: reset rst, asynchronous, active-high; clock clk_in. While rst is high:
  - div_cnt=0, px_ce=0, hpos=0, vpos=0, de=1
  - hsync and vsync at their deasserted levels
  - line_start=0, frame_start=0
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - px_ce is registered; it is high in the cycle after the edge where div_cnt becomes CLK_DIV-1.
  - With CLK_DIV=1, px_ce is 1 in every cycle after reset.
  - First px_ce pulse: CLK_DIV cycles after rst deasserts.
- Counters advance only on clk_in edges where px_ce=1:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps from V_TOTAL-1 to 0 at the same edge hpos wraps.
- hsync, vsync and de are registered decodes of the next counter values, so they are always consistent with the hpos/vpos presented in the same cycle (zero latency relative to position).
- hsync is asserted iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC. vsync changes only together with the hpos wrap.
- line_start is high for exactly the clk_in cycle in which hpos first shows 0 after a wrap.
- frame_start is high in that same cycle when vpos also wrapped to 0. line_start is also high in that cycle.
- Neither strobe fires after rst or restart; the first strobes come at the first natural wrap.
- restart:
  - On a sampled-high edge, all state returns to reset values, div_cnt included.
  - restart wins over a coincident px_ce advance.
  - Held high, it keeps the block frozen at (0,0).
- Outputs hold their values between px_ce pulses; no glitches, since every output is a flop.

Decomposition:
- Package vga_timing_pkg holds:
  - a mode record type: active/fp/sync/bp per axis, plus polarity
  - constants MODE_640x480_60 (values above, 25 MHz pixel)
  - constants MODE_800x600_60 (H 800/40/128/88, V 600/1/4/23, both positive, 40 MHz pixel)
  - a total() helper
- Sub-module vga_axis_counter: a one-dimension counter with advance input, wrap output, and sync/active decode. Instantiate it twice; the H wrap drives the V advance.

Test Plan:
- Defaults. Release rst at t0 -> hpos=vpos=0, de=1, hsync=vsync=1. px_ce first high 4 cycles later, then every 4th cycle.
- Defaults. Run to hpos=655..752 -> hsync=1 at 655, 0 for hpos 656..751, 1 at 752. de falls at hpos=640.
- Defaults. hpos=799,vpos=9 followed by px_ce -> hpos=0, vpos=10, line_start pulse of 1 clk_in cycle, frame_start=0.
- Defaults. hpos=799,vpos=524 followed by px_ce -> (0,0) with line_start=frame_start=1 for one cycle. vsync was 0 only for vpos 490..491. Frame length is 800*525*4 = 1,680,000 clk_in cycles.
- Assert restart for 1 cycle at hpos=300,vpos=200, coincident with px_ce -> next cycle (0,0), div_cnt=0, no strobes. Next frame_start arrives exactly 1,680,000 cycles later.
- CLK_DIV=1, H 4/1/2/1, V 3/1/1/1, both polarities active-high -> px_ce constant. hsync high at hpos 5..6, line period 8 cycles, frame period 48 cycles.
